ball_overlay_multi: RTL and testbench
=====================================

Name: ball_overlay_multi

Overview:
- Parametrised, pipelined successor of the single-ball disk test.
- Takes a raster pixel stream, tests each pixel against NUM_BALLS circular markers, and replaces the pixel colour with the colour of the lowest-index ball that hits.
- Ball positions, radius, enables and colours are shadow-latched once per frame, so mid-frame tracker updates cannot tear the image.
- Sits between the HSV-denoise/centroid tracker and the VGA output stage.

Parameters:
- NUM_BALLS, 2, number of independent ball channels (1..8).
- CW, 13, width of row/col coordinates.
- RW, 6, width of the runtime radius; max radius 2^RW-1.
- PW, 24, pixel colour width (8:8:8 RGB).

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of frame; latches shadow registers.
- ball_row_in  in  NUM_BALLS*CW  packed ball centre rows; channel i at [i*CW +: CW].
- ball_col_in  in  NUM_BALLS*CW  packed ball centre cols.
- ball_en_in  in  NUM_BALLS  per-channel enable.
- ball_rgb_in  in  NUM_BALLS*PW  per-channel draw colour.
- radius_in  in  RW  common radius.
- in_valid  in  1  pixel qualifier.
- in_row  in  CW  pixel row.
- in_col  in  CW  pixel col.
- in_rgb  in  PW  pixel colour.
- out_valid  out  1  delayed in_valid.
- out_rgb  out  PW  overlaid colour.
- out_hit  out  NUM_BALLS  per-channel hit flags for the output pixel.

Behaviour:
- Reset (reset_n=0 at a clk edge): all shadow registers cleared, including enables and radius. All pipeline valid bits cleared. out_valid=0, out_rgb=0, out_hit=0.
- Shadow latch: on a clk edge with frame_start=1, capture all *_in configuration inputs. New values apply to pixels entering on the following cycle and later. A pixel presented in the same cycle as frame_start uses the previous set.
- Pipeline: fixed 3-cycle latency, no backpressure. Pixel in at cycle t, result out at t+3. in_valid=0 bubbles propagate as out_valid=0. On invalid cycles out_rgb and out_hit hold their previous values.
- Stage 1, per channel:
  - dx = {0,in_col} - {0,ball_col}, signed CW+1 bits; dy likewise from rows.
  - Register |dx| and |dy|, plus near = (|dx| <= radius) && (|dy| <= radius).
- Stage 2, per channel:
  - d2 = |dx|^2 + |dy|^2, computed on the low RW bits only (valid because near guarantees the range), width 2*RW+1.
  - r2 = radius^2.
  - hit = en && near && (d2 < r2) — strict compare.
  - radius=0 never hits.
- Stage 3:
  - out_hit = hit vector.
  - out_rgb = ball_rgb[k] for the lowest k with hit[k]; otherwise the delayed in_rgb.
- Coordinate edges:
  - Centres near 0 or near 2^CW-1 must not wrap. Signed widening guarantees that col=0 with ball_col=8191 gives |dx|=8191, which is a miss.
- Reset mid-frame: pipeline is flushed, and the overlay stays disabled until the next frame_start.
- Overlapping balls: out_hit shows all hitting channels; colour priority goes to the lowest index.

Optional Feature:
- Macro: BALL_OVERLAY_RING_EN.
- Defined:
  - Adds input ring_width_in (RW bits), latched with the other shadows.
  - hit additionally requires d2 >= (radius - ring_width)^2, so each ball is drawn as an annulus.
  - If ring_width >= radius, the compare lower bound is 0, i.e. a filled disk.
  - Adds one pipeline stage for the inner-square compare; latency becomes 4.
- Undefined: filled disk, latency 3, no ring_width_in port.

Test Plan:
- Reset with reset_n=0 for 2 clks, then stream pixels without frame_start → out_valid follows in_valid at +3 cycles, out_hit=0, out_rgb=in_rgb.
- Ball0 at (100,200), r=5, en=1, rgb=FF0000, frame_start. Then pixels (100,204), (100,205), (103,204) → hit, miss (25<25 false), miss (9+16=25).
- Ball0 at (50,50), ball1 at (52,50), both r=4, colours FF0000 and 00FF00. Pixel (51,50) → out_hit=2'b11, out_rgb=FF0000.
- Change ball0 from (10,10) to (300,300) without frame_start. Pixel (10,10) → still hit. Pulse frame_start → pixel (10,10) misses, (300,300) hits. A pixel issued in the frame_start cycle uses the old position.
- Ball at (0,0), r=3. Pixels (8191,8191) and (0,2) → miss and hit (no wrap). Radius 0 → never hits.
- With BALL_OVERLAY_RING_EN, r=5, ring=2 → centre pixel misses; offset (0,4) hits (9<=16<25); offset (0,2) misses; latency 4.

Source files
------------

// File: rtl/ball_overlay_multi_if.sv
// Pixel stream interface for ball_overlay_multi.
// The master drives the input pixel (valid/row/col/colour); the slave (the
// overlay) returns the delayed, overlaid pixel and the per-ball hit flags.
interface ball_overlay_multi_if #(
  parameter int NUM_BALLS = 2,
  parameter int CW        = 13,
  parameter int PW        = 24
);
  logic                 in_valid;
  logic [CW-1:0]        in_row;
  logic [CW-1:0]        in_col;
  logic [PW-1:0]        in_rgb;
  logic                 out_valid;
  logic [PW-1:0]        out_rgb;
  logic [NUM_BALLS-1:0] out_hit;

  modport master (
    output in_valid, in_row, in_col, in_rgb,
    input  out_valid, out_rgb, out_hit
  );

  modport slave (
    input  in_valid, in_row, in_col, in_rgb,
    output out_valid, out_rgb, out_hit
  );
endinterface

// File: rtl/ball_overlay_multi.sv
// Multi-ball circular marker overlay on a raster pixel stream.
// Each pixel is tested against NUM_BALLS circles; the lowest-index hitting
// ball replaces the pixel colour. Ball configuration is shadow-latched on
// frame_start so that tracker updates never tear a frame.
// Optional: define BALL_OVERLAY_RING_EN to draw annuli (ring_width_in port,
// one extra pipeline stage, latency 4). Default build: filled disks, latency 3.
module ball_overlay_multi #(
  parameter int NUM_BALLS = 2,
  parameter int CW        = 13,
  parameter int RW        = 6,
  parameter int PW        = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [NUM_BALLS*CW-1:0] ball_row_in,
  input  logic [NUM_BALLS*CW-1:0] ball_col_in,
  input  logic [NUM_BALLS-1:0]    ball_en_in,
  input  logic [NUM_BALLS*PW-1:0] ball_rgb_in,
  input  logic [RW-1:0]           radius_in,
`ifdef BALL_OVERLAY_RING_EN
  input  logic [RW-1:0]           ring_width_in,
`endif
  ball_overlay_multi_if.slave     pix
);

  localparam int D2W = 2*RW + 1;
  localparam int R2W = 2*RW;

  // Shadow configuration, applied from the pixel after frame_start onward
  logic [NUM_BALLS*CW-1:0] sh_row_q;
  logic [NUM_BALLS*CW-1:0] sh_col_q;
  logic [NUM_BALLS-1:0]    sh_en_q;
  logic [NUM_BALLS*PW-1:0] sh_rgb_q;
  logic [RW-1:0]           sh_rad_q;
`ifdef BALL_OVERLAY_RING_EN
  logic [RW-1:0]           sh_ring_q;
`endif

  // Shadow latch: cleared on reset so the overlay stays off until a frame_start
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_row_q  <= '0;
      sh_col_q  <= '0;
      sh_en_q   <= '0;
      sh_rgb_q  <= '0;
      sh_rad_q  <= '0;
`ifdef BALL_OVERLAY_RING_EN
      sh_ring_q <= '0;
`endif
    end else if (frame_start) begin
      sh_row_q  <= ball_row_in;
      sh_col_q  <= ball_col_in;
      sh_en_q   <= ball_en_in;
      sh_rgb_q  <= ball_rgb_in;
      sh_rad_q  <= radius_in;
`ifdef BALL_OVERLAY_RING_EN
      sh_ring_q <= ring_width_in;
`endif
    end
  end

  // ---------------- Stage 1: per-channel distance magnitudes ----------------
  logic [NUM_BALLS-1:0][RW-1:0] adx_d, ady_d;
  logic [NUM_BALLS-1:0]         near_d;
  logic [R2W-1:0]               r2_d;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_s1
    logic [CW:0]   dx, dy;
    logic [CW-1:0] adx, ady;
    // Widen by one bit so centres near 0 / 2^CW-1 never wrap around
    assign dx  = {1'b0, pix.in_col} - {1'b0, sh_col_q[g*CW +: CW]};
    assign dy  = {1'b0, pix.in_row} - {1'b0, sh_row_q[g*CW +: CW]};
    assign adx = dx[CW] ? (~dx[CW-1:0] + CW'(1)) : dx[CW-1:0];
    assign ady = dy[CW] ? (~dy[CW-1:0] + CW'(1)) : dy[CW-1:0];
    // Enable is folded into near so later stages need no config copy
    assign near_d[g] = sh_en_q[g] && (adx <= CW'(sh_rad_q)) && (ady <= CW'(sh_rad_q));
    // Once near holds, both magnitudes fit in RW bits
    assign adx_d[g] = adx[RW-1:0];
    assign ady_d[g] = ady[RW-1:0];
  end

  assign r2_d = R2W'(sh_rad_q) * R2W'(sh_rad_q);

  logic                         s1_vld_q;
  logic [PW-1:0]                s1_rgb_q;
  logic [NUM_BALLS-1:0][RW-1:0] s1_adx_q, s1_ady_q;
  logic [NUM_BALLS-1:0]         s1_near_q;
  logic [R2W-1:0]               s1_r2_q;
  logic [NUM_BALLS*PW-1:0]      s1_brgb_q;
`ifdef BALL_OVERLAY_RING_EN
  logic [RW-1:0]                inner_d;
  logic [R2W-1:0]               s1_ri2_q;
  assign inner_d = (sh_ring_q >= sh_rad_q) ? '0 : (sh_rad_q - sh_ring_q);
`endif

  // Stage 1 register; radius^2 and colours travel with the pixel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_rgb_q  <= '0;
      s1_adx_q  <= '0;
      s1_ady_q  <= '0;
      s1_near_q <= '0;
      s1_r2_q   <= '0;
      s1_brgb_q <= '0;
`ifdef BALL_OVERLAY_RING_EN
      s1_ri2_q  <= '0;
`endif
    end else begin
      s1_vld_q  <= pix.in_valid;
      s1_rgb_q  <= pix.in_rgb;
      s1_adx_q  <= adx_d;
      s1_ady_q  <= ady_d;
      s1_near_q <= near_d;
      s1_r2_q   <= r2_d;
      s1_brgb_q <= sh_rgb_q;
`ifdef BALL_OVERLAY_RING_EN
      s1_ri2_q  <= R2W'(inner_d) * R2W'(inner_d);
`endif
    end
  end

  // ---------------- Stage 2: squared distance and outer compare ----------------
  logic [NUM_BALLS-1:0][D2W-1:0] d2_d;
  logic [NUM_BALLS-1:0]          outer_d;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_s2
    assign d2_d[g] = D2W'(s1_adx_q[g]) * D2W'(s1_adx_q[g])
                   + D2W'(s1_ady_q[g]) * D2W'(s1_ady_q[g]);
    // Strict compare: radius 0 can never hit
    assign outer_d[g] = s1_near_q[g] && (d2_d[g] < D2W'(s1_r2_q));
  end

  // Final pre-output stage: hit vector plus what the output mux needs
  logic                    hv_vld_q;
  logic [PW-1:0]           hv_rgb_q;
  logic [NUM_BALLS-1:0]    hv_hit_q;
  logic [NUM_BALLS*PW-1:0] hv_brgb_q;

`ifdef BALL_OVERLAY_RING_EN
  logic                          s2_vld_q;
  logic [PW-1:0]                 s2_rgb_q;
  logic [NUM_BALLS-1:0][D2W-1:0] s2_d2_q;
  logic [NUM_BALLS-1:0]          s2_outer_q;
  logic [R2W-1:0]                s2_ri2_q;
  logic [NUM_BALLS*PW-1:0]       s2_brgb_q;
  logic [NUM_BALLS-1:0]          ring_hit_d;

  // Stage 2 register (ring build): inner compare is deferred one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_vld_q   <= 1'b0;
      s2_rgb_q   <= '0;
      s2_d2_q    <= '0;
      s2_outer_q <= '0;
      s2_ri2_q   <= '0;
      s2_brgb_q  <= '0;
    end else begin
      s2_vld_q   <= s1_vld_q;
      s2_rgb_q   <= s1_rgb_q;
      s2_d2_q    <= d2_d;
      s2_outer_q <= outer_d;
      s2_ri2_q   <= s1_ri2_q;
      s2_brgb_q  <= s1_brgb_q;
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_s3
    assign ring_hit_d[g] = s2_outer_q[g] && (s2_d2_q[g] >= D2W'(s2_ri2_q));
  end

  // Stage 3 register (ring build): annulus hit vector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hv_vld_q  <= 1'b0;
      hv_rgb_q  <= '0;
      hv_hit_q  <= '0;
      hv_brgb_q <= '0;
    end else begin
      hv_vld_q  <= s2_vld_q;
      hv_rgb_q  <= s2_rgb_q;
      hv_hit_q  <= ring_hit_d;
      hv_brgb_q <= s2_brgb_q;
    end
  end
`else
  // Stage 2 register: filled-disk hit vector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hv_vld_q  <= 1'b0;
      hv_rgb_q  <= '0;
      hv_hit_q  <= '0;
      hv_brgb_q <= '0;
    end else begin
      hv_vld_q  <= s1_vld_q;
      hv_rgb_q  <= s1_rgb_q;
      hv_hit_q  <= outer_d;
      hv_brgb_q <= s1_brgb_q;
    end
  end
`endif

  // ---------------- Output stage: priority colour select ----------------
  logic [PW-1:0] sel_rgb_d;

  // Lowest-index hitting ball wins, so scan from the top down
  always_comb begin
    sel_rgb_d = hv_rgb_q;
    for (int i = NUM_BALLS-1; i >= 0; i--) begin
      if (hv_hit_q[i]) sel_rgb_d = hv_brgb_q[i*PW +: PW];
    end
  end

  logic                 out_vld_q;
  logic [PW-1:0]        out_rgb_q;
  logic [NUM_BALLS-1:0] out_hit_q;

  // Output register; colour and flags hold across bubbles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_vld_q <= 1'b0;
      out_rgb_q <= '0;
      out_hit_q <= '0;
    end else begin
      out_vld_q <= hv_vld_q;
      if (hv_vld_q) begin
        out_rgb_q <= sel_rgb_d;
        out_hit_q <= hv_hit_q;
      end
    end
  end

  assign pix.out_valid = out_vld_q;
  assign pix.out_rgb   = out_rgb_q;
  assign pix.out_hit   = out_hit_q;

endmodule

// File: tb/tb_ball_overlay_multi.sv
// Self-checking bench for ball_overlay_multi: directed scenarios plus a
// randomized phase, all compared against a geometric reference model.
module tb_ball_overlay_multi;
  localparam int NB = 2;
  localparam int CW = 13;
  localparam int RW = 6;
  localparam int PW = 24;
`ifdef BALL_OVERLAY_RING_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             frame_start;
  logic [NB*CW-1:0] ball_row_in;
  logic [NB*CW-1:0] ball_col_in;
  logic [NB-1:0]    ball_en_in;
  logic [NB*PW-1:0] ball_rgb_in;
  logic [RW-1:0]    radius_in;
`ifdef BALL_OVERLAY_RING_EN
  logic [RW-1:0]    ring_width_in;
`endif

  ball_overlay_multi_if #(.NUM_BALLS(NB), .CW(CW), .PW(PW)) pix ();

  ball_overlay_multi #(.NUM_BALLS(NB), .CW(CW), .RW(RW), .PW(PW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .ball_row_in  (ball_row_in),
    .ball_col_in  (ball_col_in),
    .ball_en_in   (ball_en_in),
    .ball_rgb_in  (ball_rgb_in),
    .radius_in    (radius_in),
`ifdef BALL_OVERLAY_RING_EN
    .ring_width_in(ring_width_in),
`endif
    .pix          (pix)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: active configuration and a plain delay line of results
  typedef struct {
    bit            vld;
    logic [PW-1:0] rgb;
    logic [NB-1:0] hit;
  } ent_t;

  int            m_row [NB];
  int            m_col [NB];
  bit            m_en  [NB];
  logic [PW-1:0] m_rgb [NB];
  int            m_rad;
  int            m_ring;
  ent_t          dq[$];
  bit            e_vld;
  logic [PW-1:0] e_rgb;
  logic [NB-1:0] e_hit;

  function automatic ent_t model_px();
    ent_t e;
    int dx, dy, d2, inner;
    e.vld = pix.in_valid;
    e.rgb = pix.in_rgb;
    e.hit = '0;
    for (int i = 0; i < NB; i++) begin
      dx = int'(pix.in_col) - m_col[i];
      dy = int'(pix.in_row) - m_row[i];
      d2 = dx*dx + dy*dy;
      inner = (m_ring >= m_rad) ? 0 : m_rad - m_ring;
`ifdef BALL_OVERLAY_RING_EN
      if (m_en[i] && d2 < m_rad*m_rad && d2 >= inner*inner) e.hit[i] = 1'b1;
`else
      if (m_en[i] && d2 < m_rad*m_rad) e.hit[i] = 1'b1;
`endif
    end
    for (int i = NB-1; i >= 0; i--) if (e.hit[i]) e.rgb = m_rgb[i];
    return e;
  endfunction

  task automatic model_clear();
    ent_t z;
    z.vld = 1'b0; z.rgb = '0; z.hit = '0;
    for (int i = 0; i < NB; i++) begin
      m_row[i] = 0; m_col[i] = 0; m_en[i] = 1'b0; m_rgb[i] = '0;
    end
    m_rad = 0; m_ring = 0;
    dq.delete();
    for (int i = 0; i < LAT-1; i++) dq.push_back(z);
    e_vld = 1'b0; e_rgb = '0; e_hit = '0;
  endtask

  // One clock: model the edge, then compare all outputs 1 time unit later
  task automatic tick();
    ent_t e, o;
    e = model_px();
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      dq.push_front(e);
      o = dq.pop_back();
      e_vld = o.vld;
      if (o.vld) begin
        e_rgb = o.rgb;
        e_hit = o.hit;
      end
      if (frame_start) begin
        for (int i = 0; i < NB; i++) begin
          m_row[i] = int'(ball_row_in[i*CW +: CW]);
          m_col[i] = int'(ball_col_in[i*CW +: CW]);
          m_en[i]  = ball_en_in[i];
          m_rgb[i] = ball_rgb_in[i*PW +: PW];
        end
        m_rad = int'(radius_in);
`ifdef BALL_OVERLAY_RING_EN
        m_ring = int'(ring_width_in);
`endif
      end
    end
    #1;
    chk("out_valid", 32'(pix.out_valid), 32'(e_vld));
    chk("out_rgb",   32'(pix.out_rgb),   32'(e_rgb));
    chk("out_hit",   32'(pix.out_hit),   32'(e_hit));
  endtask

  task automatic set_ball(input int i, input int r, input int c, input bit en, input logic [PW-1:0] rgb);
    ball_row_in[i*CW +: CW] = CW'(r);
    ball_col_in[i*CW +: CW] = CW'(c);
    ball_en_in[i]           = en;
    ball_rgb_in[i*PW +: PW] = rgb;
  endtask

  // Issue one pixel, then bubbles until its result sits on the outputs
  task automatic send_px(input int r, input int c, input logic [PW-1:0] rgb, input bit fs);
    pix.in_valid = 1'b1;
    pix.in_row   = CW'(r);
    pix.in_col   = CW'(c);
    pix.in_rgb   = rgb;
    frame_start  = fs;
    tick();
    pix.in_valid = 1'b0;
    frame_start  = 1'b0;
    repeat (LAT-1) tick();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    frame_start  = 1'b0;
    ball_row_in  = '0;
    ball_col_in  = '0;
    ball_en_in   = '0;
    ball_rgb_in  = '0;
    radius_in    = '0;
`ifdef BALL_OVERLAY_RING_EN
    ring_width_in = '1;
`endif
    pix.in_valid = 1'b0;
    pix.in_row   = '0;
    pix.in_col   = '0;
    pix.in_rgb   = '0;
    model_clear();

    // Reset, then pass-through with no configuration latched
    repeat (2) tick();
    chk("rst_valid", 32'(pix.out_valid), 32'd0);
    chk("rst_rgb",   32'(pix.out_rgb),   32'd0);
    chk("rst_hit",   32'(pix.out_hit),   32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pix.in_valid = (k % 3) != 1;
      pix.in_row   = CW'($urandom);
      pix.in_col   = CW'($urandom);
      pix.in_rgb   = PW'($urandom);
      tick();
    end
    pix.in_valid = 1'b0;
    send_px(7, 9, 24'h123456, 1'b0);
    chk("pass_rgb", 32'(pix.out_rgb), 32'h123456);
    chk("pass_hit", 32'(pix.out_hit), 32'd0);
    chk("pass_vld", 32'(pix.out_valid), 32'd1);

    // Single ball, strict boundary
    set_ball(0, 100, 200, 1'b1, 24'hFF0000);
    radius_in = 6'd5;
    pulse_fs();
    send_px(100, 204, 24'h0000AA, 1'b0);
    chk("b0_hit_in",   32'(pix.out_hit), 32'd1);
    chk("b0_rgb_in",   32'(pix.out_rgb), 32'hFF0000);
    send_px(100, 205, 24'h0000AA, 1'b0);
    chk("b0_edge_miss", 32'(pix.out_hit), 32'd0);
    chk("b0_edge_rgb",  32'(pix.out_rgb), 32'h0000AA);
    send_px(103, 204, 24'h0000BB, 1'b0);
    chk("b0_diag_miss", 32'(pix.out_hit), 32'd0);

    // Overlap: both flags, lowest index colour
    set_ball(0, 50, 50, 1'b1, 24'hFF0000);
    set_ball(1, 52, 50, 1'b1, 24'h00FF00);
    radius_in = 6'd4;
    pulse_fs();
    send_px(51, 50, 24'h000011, 1'b0);
    chk("ovl_hit", 32'(pix.out_hit), 32'd3);
    chk("ovl_rgb", 32'(pix.out_rgb), 32'hFF0000);

    // Shadow latching
    set_ball(1, 0, 0, 1'b0, 24'h00FF00);
    set_ball(0, 10, 10, 1'b1, 24'hFF0000);
    pulse_fs();
    set_ball(0, 300, 300, 1'b1, 24'hFF0000);
    send_px(10, 10, 24'h000022, 1'b0);
    chk("shd_old_hit", 32'(pix.out_hit), 32'd1);
    send_px(10, 10, 24'h000022, 1'b1);
    chk("shd_fs_cycle", 32'(pix.out_hit), 32'd1);
    send_px(10, 10, 24'h000022, 1'b0);
    chk("shd_new_miss", 32'(pix.out_hit), 32'd0);
    send_px(300, 300, 24'h000022, 1'b0);
    chk("shd_new_hit", 32'(pix.out_hit), 32'd1);

    // Coordinate edges: no wrap
    set_ball(0, 0, 0, 1'b1, 24'hFF0000);
    radius_in = 6'd3;
    pulse_fs();
    send_px(8191, 8191, 24'h000033, 1'b0);
    chk("edge_wrap_miss", 32'(pix.out_hit), 32'd0);
    send_px(0, 2, 24'h000033, 1'b0);
    chk("edge_hit", 32'(pix.out_hit), 32'd1);
    set_ball(0, 8191, 0, 1'b1, 24'hFF0000);
    pulse_fs();
    send_px(0, 0, 24'h000044, 1'b0);
    chk("edge_row_miss", 32'(pix.out_hit), 32'd0);
    radius_in = 6'd0;
    set_ball(0, 0, 0, 1'b1, 24'hFF0000);
    pulse_fs();
    send_px(0, 0, 24'h000055, 1'b0);
    chk("r0_miss", 32'(pix.out_hit), 32'd0);

`ifdef BALL_OVERLAY_RING_EN
    // Annulus
    set_ball(0, 20, 20, 1'b1, 24'hFF0000);
    radius_in     = 6'd5;
    ring_width_in = 6'd2;
    pulse_fs();
    send_px(20, 20, 24'h000066, 1'b0);
    chk("ring_ctr_miss", 32'(pix.out_hit), 32'd0);
    send_px(20, 24, 24'h000066, 1'b0);
    chk("ring_hit", 32'(pix.out_hit), 32'd1);
    send_px(20, 22, 24'h000066, 1'b0);
    chk("ring_inner_miss", 32'(pix.out_hit), 32'd0);
    ring_width_in = '1;
`endif

    // Mid-frame reset disables the overlay until the next frame_start
    set_ball(0, 40, 40, 1'b1, 24'hFF0000);
    radius_in = 6'd6;
    pulse_fs();
    pix.in_valid = 1'b1;
    pix.in_row   = CW'(40);
    pix.in_col   = CW'(40);
    pix.in_rgb   = 24'h000077;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    pix.in_valid = 1'b0;
    repeat (LAT) tick();
    chk("mrst_vld", 32'(pix.out_valid), 32'd0);
    send_px(40, 40, 24'h000088, 1'b0);
    chk("mrst_off_hit", 32'(pix.out_hit), 32'd0);
    chk("mrst_off_rgb", 32'(pix.out_rgb), 32'h000088);
    pulse_fs();
    send_px(40, 40, 24'h000088, 1'b0);
    chk("mrst_on_hit", 32'(pix.out_hit), 32'd1);

    // Randomized phase against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        for (int i = 0; i < NB; i++) begin
          if ($urandom_range(0, 7) == 0)
            set_ball(i, ($urandom_range(0, 1) != 0) ? 8191 : 0, $urandom_range(0, 8191),
                     1'($urandom), PW'($urandom));
          else
            set_ball(i, $urandom_range(0, 40), $urandom_range(0, 40),
                     ($urandom_range(0, 3) != 0), PW'($urandom));
        end
        radius_in = RW'($urandom_range(0, 20));
`ifdef BALL_OVERLAY_RING_EN
        ring_width_in = RW'($urandom_range(0, 24));
`endif
      end
      frame_start  = ($urandom_range(0, 19) == 0);
      reset_n      = ($urandom_range(0, 599) != 0);
      pix.in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        pix.in_row = CW'($urandom);
        pix.in_col = CW'($urandom);
      end else begin
        pix.in_row = CW'($urandom_range(0, 48));
        pix.in_col = CW'($urandom_range(0, 48));
      end
      pix.in_rgb = PW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
